// File: rtl/clock_pkg.sv
// Shared types, BCD limits and BCD increment helpers for the alarm clock controller.
package clock_pkg;

    typedef enum logic [1:0] {
        EDIT_NONE = 2'd0,
        EDIT_HH   = 2'd1,
        EDIT_MM   = 2'd2
    } edit_state_e;

    typedef enum logic [1:0] {
        AL_IDLE   = 2'd0,
        AL_RING   = 2'd1,
        AL_SNOOZE = 2'd2
    } alarm_state_e;

    localparam logic [7:0] HH_MIN     = 8'h01;
    localparam logic [7:0] HH_MAX     = 8'h12;
    localparam logic [7:0] HH_PM_EDGE = 8'h11;
    localparam logic [7:0] MM_MAX     = 8'h59;

    // Minutes wrap 59 -> 00 without producing any carry.
    function automatic logic [7:0] bcd_inc_mod60(input logic [7:0] v);
        logic [7:0] r;
        if (v == MM_MAX) begin
            r = 8'h00;
        end else if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = v + 8'h01;
        end
        return r;
    endfunction

    // Hours run 12 -> 01 -> ... -> 11 -> 12.
    function automatic logic [7:0] bcd_inc_hour12(input logic [7:0] v);
        logic [7:0] r;
        if (v == HH_MAX) begin
            r = HH_MIN;
        end else if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = v + 8'h01;
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_tick_gen.sv
// Prescaler producing a registered one-cycle tick every TICK_DIV enabled clocks.
module clock_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_en_i,
    output logic tick_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count_q, count_d;
    logic          tick_q, tick_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    // With run_en low the count freezes so timekeeping resumes without a phase jump.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (run_en_i) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/clock_alarm_ctrl.sv
// Alarm controller: tick generation, BCD alarm editing and ring/snooze sequencing
// on top of the 12-hour BCD timer outputs.
module clock_alarm_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_en_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       btn_stop_i,
    input  logic       alarm_arm_i,
    input  logic [7:0] cur_hh_i,
    input  logic [7:0] cur_mm_i,
    input  logic [7:0] cur_ss_i,
    input  logic       cur_pm_i,
    output logic       tick_ena_o,
    output logic [7:0] al_hh_o,
    output logic [7:0] al_mm_o,
    output logic       al_pm_o,
    output logic [1:0] editing_o,
    output logic       ringing_o,
    output logic       snoozing_o
);

    localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SECS);
    localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SECS);

    edit_state_e  edit_q, edit_d;
    alarm_state_e al_state_q, al_state_d;
    logic [7:0]   al_hh_q, al_hh_d;
    logic [7:0]   al_mm_q, al_mm_d;
    logic         al_pm_q, al_pm_d;
    logic         match_q;
    logic [CW-1:0] ring_cnt_q, ring_cnt_d;
    logic [CW-1:0] snooze_cnt_q, snooze_cnt_d;

    logic tick;
    logic match;
    logic trigger;
    logic alarm_busy;
    logic snooze_req;

    clock_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .run_en_i (run_en_i),
        .tick_o   (tick)
    );

    assign match = (cur_hh_i == al_hh_q) && (cur_mm_i == al_mm_q) &&
                   (cur_pm_i == al_pm_q) && (cur_ss_i == 8'h00);
    assign trigger    = match && !match_q;
    assign alarm_busy = (al_state_q == AL_RING) || (al_state_q == AL_SNOOZE);
    // A mode press consumes a simultaneous inc, and inc only snoozes outside edit mode.
    assign snooze_req = btn_inc_i && !btn_mode_i && (edit_q == EDIT_NONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edit_q       <= EDIT_NONE;
            al_state_q   <= AL_IDLE;
            al_hh_q      <= HH_MAX;
            al_mm_q      <= 8'h00;
            al_pm_q      <= 1'b0;
            match_q      <= 1'b0;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
        end else begin
            edit_q       <= edit_d;
            al_state_q   <= al_state_d;
            al_hh_q      <= al_hh_d;
            al_mm_q      <= al_mm_d;
            al_pm_q      <= al_pm_d;
            match_q      <= match;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
        end
    end

    always_comb begin
        edit_d  = edit_q;
        al_hh_d = al_hh_q;
        al_mm_d = al_mm_q;
        al_pm_d = al_pm_q;
        if (btn_mode_i) begin
            if (!alarm_busy) begin
                case (edit_q)
                    EDIT_NONE: edit_d = EDIT_HH;
                    EDIT_HH:   edit_d = EDIT_MM;
                    default:   edit_d = EDIT_NONE;
                endcase
            end
        end else if (btn_inc_i) begin
            case (edit_q)
                EDIT_HH: begin
                    al_hh_d = bcd_inc_hour12(al_hh_q);
                    if (al_hh_q == HH_PM_EDGE) begin
                        al_pm_d = !al_pm_q;
                    end
                end
                EDIT_MM: al_mm_d = bcd_inc_mod60(al_mm_q);
                default: ;
            endcase
        end
    end

    // Priority: disarm, stop, snooze, then counter expiry.
    always_comb begin
        al_state_d   = al_state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        if (!alarm_arm_i) begin
            al_state_d = AL_IDLE;
        end else begin
            case (al_state_q)
                AL_IDLE: begin
                    if (trigger && (edit_q == EDIT_NONE)) begin
                        al_state_d = AL_RING;
                        ring_cnt_d = RING_LOAD;
                    end
                end
                AL_RING: begin
                    if (btn_stop_i) begin
                        al_state_d = AL_IDLE;
                    end else if (snooze_req) begin
                        al_state_d   = AL_SNOOZE;
                        snooze_cnt_d = SNOOZE_LOAD;
                    end else if (ring_cnt_q == '0) begin
                        al_state_d = AL_IDLE;
                    end else if (tick) begin
                        ring_cnt_d = ring_cnt_q - 1'b1;
                    end
                end
                AL_SNOOZE: begin
                    if (btn_stop_i) begin
                        al_state_d = AL_IDLE;
                    end else if (snooze_cnt_q == '0) begin
                        al_state_d = AL_RING;
                        ring_cnt_d = RING_LOAD;
                    end else if (tick) begin
                        snooze_cnt_d = snooze_cnt_q - 1'b1;
                    end
                end
                default: al_state_d = AL_IDLE;
            endcase
        end
    end

    assign tick_ena_o = tick;
    assign al_hh_o    = al_hh_q;
    assign al_mm_o    = al_mm_q;
    assign al_pm_o    = al_pm_q;
    assign editing_o  = edit_q;
    assign ringing_o  = (al_state_q == AL_RING);
    assign snoozing_o = (al_state_q == AL_SNOOZE);

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Directed self-checking bench for clock_alarm_ctrl with short tick, ring and snooze periods.
module tb_clock_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic       runEn;
    logic       btnMode;
    logic       btnInc;
    logic       btnStop;
    logic       alarmArm;
    logic [7:0] curHh;
    logic [7:0] curMm;
    logic [7:0] curSs;
    logic       curPm;
    logic       tickEna;
    logic [7:0] alHh;
    logic [7:0] alMm;
    logic       alPm;
    logic [1:0] editing;
    logic       ringing;
    logic       snoozing;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_alarm_ctrl #(
        .TICK_DIV    (4),
        .RING_SECS   (3),
        .SNOOZE_SECS (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .run_en_i    (runEn),
        .btn_mode_i  (btnMode),
        .btn_inc_i   (btnInc),
        .btn_stop_i  (btnStop),
        .alarm_arm_i (alarmArm),
        .cur_hh_i    (curHh),
        .cur_mm_i    (curMm),
        .cur_ss_i    (curSs),
        .cur_pm_i    (curPm),
        .tick_ena_o  (tickEna),
        .al_hh_o     (alHh),
        .al_mm_o     (alMm),
        .al_pm_o     (alPm),
        .editing_o   (editing),
        .ringing_o   (ringing),
        .snoozing_o  (snoozing)
    );

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic inc, input logic stop);
        btnMode = mode;
        btnInc  = inc;
        btnStop = stop;
        stepCycle();
        btnMode = 1'b0;
        btnInc  = 1'b0;
        btnStop = 1'b0;
    endtask

    task automatic pressInc(input int n);
        repeat (n) applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic waitTicks(input int n, input string tag);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 200) begin
            stepCycle();
            cyc++;
            if (tickEna) seen++;
        end
        checkOutput(tag, seen, n);
    endtask

    task automatic retrigger();
        curSs = 8'h01;
        stepCycle();
        curSs = 8'h00;
        stepCycle();
    endtask

    initial begin
        int pulses;
        int firstTick;

        rstN = 1'b0; runEn = 1'b0; btnMode = 1'b0; btnInc = 1'b0; btnStop = 1'b0;
        alarmArm = 1'b0; curHh = 8'h01; curMm = 8'h00; curSs = 8'h01; curPm = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("reset_tick", tickEna, 1'b0);
        checkOutput("reset_al_hh", alHh, 8'h12);
        checkOutput("reset_al_mm", alMm, 8'h00);
        checkOutput("reset_al_pm", alPm, 1'b0);
        checkOutput("reset_editing", editing, 2'd0);
        checkOutput("reset_ringing", ringing, 1'b0);
        checkOutput("reset_snoozing", snoozing, 1'b0);

        $display("[TB] prescaler");
        rstN = 1'b1;
        runEn = 1'b1;
        pulses = 0;
        repeat (20) begin
            stepCycle();
            if (tickEna) pulses++;
        end
        checkOutput("tick_pulses_run", pulses, 5);
        runEn = 1'b0;
        pulses = 0;
        repeat (10) begin
            stepCycle();
            if (tickEna) pulses++;
        end
        checkOutput("tick_pulses_hold", pulses, 0);
        runEn = 1'b1;
        firstTick = 0;
        for (int i = 1; i <= 4; i++) begin
            stepCycle();
            if (tickEna && firstTick == 0) firstTick = i;
        end
        checkOutput("tick_resume_pos", firstTick, 4);
        runEn = 1'b0;
        stepCycle();

        $display("[TB] alarm edit");
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("mode_inc_editing", editing, 2'd1);
        checkOutput("mode_inc_hh_kept", alHh, 8'h12);
        pressInc(1);
        checkOutput("hh_12_to_01", alHh, 8'h01);
        pressInc(9);
        checkOutput("hh_bcd_10", alHh, 8'h10);
        pressInc(1);
        checkOutput("hh_11", alHh, 8'h11);
        checkOutput("pm_before_edge", alPm, 1'b0);
        pressInc(1);
        checkOutput("hh_11_to_12", alHh, 8'h12);
        checkOutput("pm_toggled", alPm, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("editing_mm", editing, 2'd2);
        pressInc(60);
        checkOutput("mm_wrap_00", alMm, 8'h00);
        pressInc(1);
        checkOutput("mm_01", alMm, 8'h01);
        checkOutput("mm_no_carry", alHh, 8'h12);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("editing_none", editing, 2'd0);

        $display("[TB] ring and auto-stop");
        rstN = 1'b0;
        #1;
        checkOutput("async_reset_mm", alMm, 8'h00);
        stepCycle();
        rstN = 1'b1;
        curHh = 8'h07; curMm = 8'h30; curPm = 1'b0; curSs = 8'h01;
        applyStimulus(1'b1, 1'b0, 1'b0);
        pressInc(7);
        checkOutput("set_hh_07", alHh, 8'h07);
        checkOutput("set_pm_am", alPm, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pressInc(30);
        checkOutput("set_mm_30", alMm, 8'h30);
        applyStimulus(1'b1, 1'b0, 1'b0);
        alarmArm = 1'b1;
        retrigger();
        checkOutput("ring_on_match", ringing, 1'b1);
        runEn = 1'b1;
        waitTicks(2, "ring_ticks_a");
        checkOutput("ring_after_2_ticks", ringing, 1'b1);
        waitTicks(1, "ring_ticks_b");
        stepCycle();
        checkOutput("ring_count_zero", ringing, 1'b1);
        stepCycle();
        checkOutput("ring_auto_stop", ringing, 1'b0);
        runEn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("no_retrigger", ringing, 1'b0);
        end

        $display("[TB] snooze");
        retrigger();
        checkOutput("ring_again", ringing, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("snooze_on", snoozing, 1'b1);
        checkOutput("snooze_ring_off", ringing, 1'b0);
        runEn = 1'b1;
        waitTicks(2, "snooze_ticks");
        stepCycle();
        checkOutput("snooze_count_zero", snoozing, 1'b1);
        stepCycle();
        checkOutput("snooze_rering", ringing, 1'b1);
        checkOutput("snooze_off", snoozing, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stop_ringing", ringing, 1'b0);
        checkOutput("stop_snoozing", snoozing, 1'b0);
        runEn = 1'b0;
        stepCycle();

        $display("[TB] priorities");
        retrigger();
        checkOutput("prio_ring", ringing, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("stop_beats_inc_ring", ringing, 1'b0);
        checkOutput("stop_beats_inc_snz", snoozing, 1'b0);
        retrigger();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("disarm_pre_snooze", snoozing, 1'b1);
        alarmArm = 1'b0;
        stepCycle();
        checkOutput("disarm_snoozing", snoozing, 1'b0);
        checkOutput("disarm_ringing", ringing, 1'b0);
        alarmArm = 1'b1;

        $display("[TB] edit blocking and async reset");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("edit_hh_active", editing, 2'd1);
        retrigger();
        checkOutput("no_ring_while_edit", ringing, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("edit_back_none", editing, 2'd0);
        retrigger();
        checkOutput("ring_before_reset", ringing, 1'b1);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("midring_reset_ringing", ringing, 1'b0);
        checkOutput("midring_reset_al_hh", alHh, 8'h12);
        checkOutput("midring_reset_al_mm", alMm, 8'h00);
        checkOutput("midring_reset_editing", editing, 2'd0);
        stepCycle();
        rstN = 1'b1;
        stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
